rgb_sort_sched: RTL and testbench

Controller sitting between the per-block colour accumulator and the 16-entry RGB sorter in the klotski camera path. It collects one average colour per tile of the 4x4 grid each frame, launches the sorter, and captures the 64-bit tile order with a timeout. It publishes an order downstream only after it has been stable for STABLE_FRAMES consecutive frames.

---
 rtl/rgb_sort_sched.sv | 134 +++++++++++++
 tb/tb_rgb_sort_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sort_sched.sv
// Per-frame tile colour collector and sorter launcher for the 4x4 klotski grid.
// An order is published only after STABLE_FRAMES identical sorter results in a row.
module rgb_sort_sched #(
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT       = 64
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_blk_valid,
    input  logic [3:0]     i_blk_idx,
    input  logic [23:0]    i_blk_rgb,
    input  logic           i_frame_end,
    output logic           o_sort_start,
    output logic [383:0]   o_sort_blocks,
    input  logic           i_sort_done,
    input  logic [63:0]    i_sort_order,
    output logic [63:0]    o_order,
    output logic           o_order_valid,
    input  logic           i_order_ready,
    output logic           o_busy,
    output logic           o_timeout,
    output logic [7:0]     o_drop_cnt
);
    localparam logic [2:0] S_COLLECT = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    localparam int              WCW     = $clog2(TIMEOUT);
    localparam logic [WCW-1:0]  WC_LAST = WCW'(TIMEOUT - 1);
    localparam logic [3:0]      SF      = 4'(STABLE_FRAMES);

    logic [2:0]        state;
    logic [15:0][23:0] buffer;
    logic [15:0]       mask, mask_nxt;
    logic [WCW-1:0]    wait_cnt;
    logic [63:0]       captured, prev, last_pub;
    logic              prev_valid, pub_valid;
    logic [3:0]        stable_cnt, stable_nxt;
    logic              same, publish, timeout_hit, drop_evt;

    // Completeness must include a tile written in the frame_end cycle itself.
    always_comb begin
        mask_nxt = mask;
        if (i_blk_valid) mask_nxt[i_blk_idx] = 1'b1;
    end

    always_comb begin
        same        = prev_valid && (captured == prev);
        stable_nxt  = same ? ((stable_cnt >= SF) ? SF : stable_cnt + 4'd1) : 4'd1;
        publish     = (stable_nxt == SF) && (!pub_valid || captured != last_pub);
        timeout_hit = (state == S_WAIT) && !i_sort_done && (wait_cnt == WC_LAST);
        drop_evt    = i_frame_end && ((state != S_COLLECT) || (mask_nxt != 16'hFFFF));
    end

    assign o_sort_start  = (state == S_START);
    assign o_busy        = (state != S_COLLECT);
    assign o_order_valid = (state == S_OUT);
    assign o_timeout     = timeout_hit;
    assign o_sort_blocks = buffer;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_drop_cnt <= '0;
        end else if (drop_evt && o_drop_cnt != 8'hFF) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_COLLECT;
            buffer     <= '0;
            mask       <= '0;
            wait_cnt   <= '0;
            captured   <= '0;
            prev       <= '0;
            last_pub   <= '0;
            prev_valid <= 1'b0;
            pub_valid  <= 1'b0;
            stable_cnt <= '0;
            o_order    <= '0;
        end else begin
            // A partial frame never survives a busy period.
            if (state != S_COLLECT) mask <= '0;
            case (state)
                S_COLLECT: begin
                    if (i_blk_valid) buffer[i_blk_idx] <= i_blk_rgb;
                    if (i_frame_end) begin
                        mask <= '0;
                        if (mask_nxt == 16'hFFFF) state <= S_START;
                    end else begin
                        mask <= mask_nxt;
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (i_sort_done) begin
                        captured <= i_sort_order;
                        state    <= S_CHECK;
                    end else if (timeout_hit) begin
                        stable_cnt <= '0;
                        prev_valid <= 1'b0;
                        state      <= S_COLLECT;
                    end
                end
                S_CHECK: begin
                    stable_cnt <= stable_nxt;
                    if (!same) begin
                        prev       <= captured;
                        prev_valid <= 1'b1;
                    end
                    if (publish) begin
                        o_order   <= captured;
                        last_pub  <= captured;
                        pub_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        state <= S_COLLECT;
                    end
                end
                S_OUT: begin
                    if (i_order_ready) state <= S_COLLECT;
                end
                default: state <= S_COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_sort_sched.sv
// Directed bench for rgb_sort_sched: collection, stability filter, timeout, drops, reset.
module tb_rgb_sort_sched;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic [3:0]   blk_idx = '0;
    logic [23:0]  blk_rgb = '0;
    logic         frame_end = 1'b0;
    logic         sort_start;
    logic [383:0] sort_blocks;
    logic         sort_done = 1'b0;
    logic [63:0]  sort_order = '0;
    logic [63:0]  order;
    logic         order_valid;
    logic         order_ready = 1'b0;
    logic         busy;
    logic         timeout;
    logic [7:0]   drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] ORD_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ORD_B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] ORD_C = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] ORD_D = 64'h1111_2222_3333_4444;

    always #5 clk = ~clk;

    rgb_sort_sched #(.STABLE_FRAMES(3), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_blk_valid(blk_valid), .i_blk_idx(blk_idx), .i_blk_rgb(blk_rgb),
        .i_frame_end(frame_end),
        .o_sort_start(sort_start), .o_sort_blocks(sort_blocks),
        .i_sort_done(sort_done), .i_sort_order(sort_order),
        .o_order(order), .o_order_valid(order_valid), .i_order_ready(order_ready),
        .o_busy(busy), .o_timeout(timeout), .o_drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [383:0] exp_blocks(input logic [23:0] seed);
        logic [383:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[24*k +: 24] = seed + 24'(k);
        return v;
    endfunction

    // Full frame, frame_end coincident with tile 15; returns in the S_START cycle.
    task automatic send_frame(input logic [23:0] seed);
        for (int k = 0; k < 16; k++) begin
            blk_valid = 1'b1;
            blk_idx   = 4'(k);
            blk_rgb   = seed + 24'(k);
            frame_end = (k == 15);
            step();
        end
        blk_valid = 1'b0;
        frame_end = 1'b0;
        chk("start_pulse", 384'(sort_start), 384'(1));
        chk("blocks", sort_blocks, exp_blocks(seed));
    endtask

    // Sorter answers on the first wait cycle; optional held-off handshake.
    task automatic run_sort(input logic [63:0] ord, input bit exp_pub, input int hold);
        step();
        sort_done  = 1'b1;
        sort_order = ord;
        step();
        sort_done  = 1'b0;
        step();
        chk("pub_valid", 384'(order_valid), 384'(exp_pub));
        if (exp_pub) begin
            chk("pub_order", 384'(order), 384'(ord));
            for (int i = 0; i < hold; i++) begin
                step();
                chk("hold_valid", 384'(order_valid), 384'(1));
                chk("hold_order", 384'(order), 384'(ord));
            end
            order_ready = 1'b1;
            step();
            order_ready = 1'b0;
            chk("accept_valid", 384'(order_valid), 384'(0));
            chk("accept_order", 384'(order), 384'(ord));
        end
    endtask

    task automatic frame(input logic [23:0] seed, input logic [63:0] ord, input bit exp_pub,
                         input int hold);
        send_frame(seed);
        run_sort(ord, exp_pub, hold);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", 384'(busy), 384'(0));
        chk("rst_start", 384'(sort_start), 384'(0));
        chk("rst_valid", 384'(order_valid), 384'(0));
        chk("rst_order", 384'(order), 384'(0));
        chk("rst_drop", 384'(drop_cnt), 384'(0));
        chk("rst_timeout", 384'(timeout), 384'(0));
        chk("rst_blocks", sort_blocks, 384'(0));
        rst = 1'b0;
        step();

        // Partial frame 0..14 is dropped
        for (int k = 0; k < 15; k++) begin
            blk_valid = 1'b1;
            blk_idx   = 4'(k);
            blk_rgb   = 24'h400000 + 24'(k);
            step();
        end
        blk_valid = 1'b0;
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chk("partial_nostart", 384'(sort_start), 384'(0));
        chk("partial_busy", 384'(busy), 384'(0));
        chk("partial_drop", 384'(drop_cnt), 384'(1));

        // Full frame with tile 3 resent last, together with frame_end
        for (int k = 0; k < 16; k++) begin
            blk_valid = 1'b1;
            blk_idx   = 4'(k);
            blk_rgb   = 24'h500000 + 24'(k);
            step();
        end
        blk_idx   = 4'd3;
        blk_rgb   = 24'h00FF00;
        frame_end = 1'b1;
        step();
        blk_valid = 1'b0;
        frame_end = 1'b0;
        chk("dup_start", 384'(sort_start), 384'(1));
        chk("dup_tile3", 384'(sort_blocks[95:72]), 384'(24'h00FF00));
        chk("dup_tile4", 384'(sort_blocks[119:96]), 384'(24'h500004));

        // Asynchronous reset in the middle of S_WAIT
        step();
        step();
        chk("wait_busy", 384'(busy), 384'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 384'(busy), 384'(0));
        chk("arst_drop", 384'(drop_cnt), 384'(0));
        chk("arst_blocks", sort_blocks, 384'(0));
        chk("arst_valid", 384'(order_valid), 384'(0));
        step();
        rst = 1'b0;
        step();

        // Three identical results publish on the third, with a held-off handshake
        frame(24'h102030, ORD_A, 1'b0, 0);
        frame(24'h102030, ORD_A, 1'b0, 0);
        frame(24'h102030, ORD_A, 1'b1, 5);

        // Same order again never republishes
        frame(24'h203040, ORD_A, 1'b0, 0);
        frame(24'h203040, ORD_A, 1'b0, 0);
        frame(24'h203040, ORD_A, 1'b0, 0);
        // New order B needs its own three frames
        frame(24'h304050, ORD_B, 1'b0, 0);
        frame(24'h304050, ORD_B, 1'b0, 0);
        frame(24'h304050, ORD_B, 1'b1, 0);
        // A,A,B,A never reaches three in a row
        frame(24'h405060, ORD_A, 1'b0, 0);
        frame(24'h405060, ORD_A, 1'b0, 0);
        frame(24'h405060, ORD_B, 1'b0, 0);
        frame(24'h405060, ORD_A, 1'b0, 0);

        // Sorter never answers: timeout TO cycles after the start pulse
        send_frame(24'h600000);
        for (int i = 0; i < TO - 1; i++) step();
        chk("to_early", 384'(timeout), 384'(0));
        step();
        chk("to_pulse", 384'(timeout), 384'(1));
        step();
        chk("to_after", 384'(timeout), 384'(0));
        chk("to_idle", 384'(busy), 384'(0));
        chk("to_novalid", 384'(order_valid), 384'(0));

        // Done on exactly the timeout cycle wins and is captured
        send_frame(24'h700000);
        for (int i = 0; i < TO; i++) step();
        sort_done  = 1'b1;
        sort_order = ORD_C;
        #1;
        chk("done_vs_to", 384'(timeout), 384'(0));
        step();
        sort_done = 1'b0;
        chk("done_check_busy", 384'(busy), 384'(1));
        step();
        chk("done_nopub", 384'(order_valid), 384'(0));
        frame(24'h700000, ORD_C, 1'b0, 0);
        frame(24'h700000, ORD_C, 1'b1, 0);

        // Drop counter saturation with frame_end during S_WAIT and S_OUT
        frame_end = 1'b1;
        for (int i = 0; i < 253; i++) step();
        frame_end = 1'b0;
        chk("drop_253", 384'(drop_cnt), 384'(253));
        frame(24'h800000, ORD_D, 1'b0, 0);
        frame(24'h800000, ORD_D, 1'b0, 0);
        send_frame(24'h800000);
        step();
        blk_valid = 1'b1;
        blk_idx   = 4'd5;
        blk_rgb   = 24'hFFFFFF;
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        frame_end = 1'b1;
        step();
        blk_valid = 1'b0;
        frame_end = 1'b0;
        chk("drop_wait", 384'(drop_cnt), 384'(255));
        chk("wait_blocks", sort_blocks, exp_blocks(24'h800000));
        sort_done  = 1'b1;
        sort_order = ORD_D;
        step();
        sort_done = 1'b0;
        step();
        chk("d_pub", 384'(order_valid), 384'(1));
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chk("drop_sat", 384'(drop_cnt), 384'(255));
        chk("d_hold", 384'(order_valid), 384'(1));
        order_ready = 1'b1;
        step();
        order_ready = 1'b0;
        chk("d_accept", 384'(order_valid), 384'(0));
        chk("d_order", 384'(order), 384'(ORD_D));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
